// File: rtl/h264_xform_arb_pkg.sv
// Shared types for the luma/chroma transform-port arbiter.
package h264_xform_arb_pkg;

    localparam int unsigned DEFAULT_DW = 36;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LUMA   = 2'd1,
        CHROMA = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_LUMA   = 1'b0,
        SRC_CHROMA = 1'b1
    } arb_src_e;

endpackage

// File: rtl/h264_credit_counter.sv
// Counts blocks granted but not yet returned; guards against overflow and underflow.
module h264_credit_counter #(
    parameter int unsigned LIMIT = 2,
    parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          avail,
    output logic          underflow
);

    always_comb begin
        avail     = (count < CW'(LIMIT));
        // A return with nothing outstanding is dropped and flagged; a same-cycle grant cancels it.
        underflow = dec && !inc && (count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && avail) begin
            count <= count + CW'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/h264_xform_arbiter.sv
// Shares the forward transform input between luma intra4x4 and chroma intra8x8cc,
// one 4x4 block burst per grant, throttled by reconstruction credits.
module h264_xform_arbiter
    import h264_xform_arb_pkg::*;
#(
    parameter int unsigned BEATS        = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned DW           = DEFAULT_DW
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              LREQ,
    input  logic                              LSTROBE,
    input  logic [DW-1:0]                     LDATA,
    output logic                              LGRANT,
    input  logic                              CREQ,
    input  logic                              CSTROBE,
    input  logic [DW-1:0]                     CDATA,
    output logic                              CGRANT,
    output logic                              XSTROBE,
    output logic [DW-1:0]                     XDATA,
    output logic                              XSRC,
    output logic                              XFIRST,
    input  logic                              FBSTROBE,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] INFLIGHT,
    output logic                              BUSY,
    output logic                              PROTERR
);

    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

    arb_state_e    state_q, state_d;
    arb_src_e      last_src_q, win;
    logic [CW-1:0] beat_cnt_q;
    logic          grant_go;
    logic          luma_acc, chroma_acc, accept, last_beat, stray;
    logic          avail, underflow;
    logic [IW-1:0] inflight;

    logic          xstrobe_q, xfirst_q, proterr_q;
    logic [DW-1:0] xdata_q;
    arb_src_e      xsrc_q;

    h264_credit_counter #(
        .LIMIT (MAX_INFLIGHT),
        .CW    (IW)
    ) u_credit (
        .clk       (CLK),
        .rst       (RESET),
        .inc       (grant_go),
        .dec       (FBSTROBE),
        .count     (inflight),
        .avail     (avail),
        .underflow (underflow)
    );

    always_comb begin
        luma_acc   = (state_q == LUMA) && LSTROBE;
        chroma_acc = (state_q == CHROMA) && CSTROBE;
        accept     = luma_acc || chroma_acc;
        last_beat  = accept && (beat_cnt_q == CW'(BEATS - 1));
        stray      = (LSTROBE && (state_q != LUMA)) || (CSTROBE && (state_q != CHROMA));
    end

    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        win      = last_src_q;
        case (state_q)
            IDLE: begin
                // Eligibility uses the credit count before this cycle's update.
                if (avail && (LREQ || CREQ)) begin
                    grant_go = 1'b1;
                    if (LREQ && CREQ) begin
                        win = (last_src_q == SRC_LUMA) ? SRC_CHROMA : SRC_LUMA;
                    end else begin
                        win = LREQ ? SRC_LUMA : SRC_CHROMA;
                    end
                    state_d = (win == SRC_LUMA) ? LUMA : CHROMA;
                end
            end
            LUMA, CHROMA: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            last_src_q <= SRC_CHROMA;
            beat_cnt_q <= '0;
            proterr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            proterr_q <= proterr_q | stray | underflow;
            if (grant_go) begin
                last_src_q <= win;
                beat_cnt_q <= '0;
            end else if (accept) begin
                beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            xstrobe_q <= 1'b0;
            xfirst_q  <= 1'b0;
            xdata_q   <= '0;
            xsrc_q    <= SRC_LUMA;
        end else begin
            xstrobe_q <= accept;
            xfirst_q  <= accept && (beat_cnt_q == '0);
            if (accept) begin
                xdata_q <= luma_acc ? LDATA : CDATA;
                xsrc_q  <= chroma_acc ? SRC_CHROMA : SRC_LUMA;
            end
        end
    end

    always_comb begin
        LGRANT   = (state_q == LUMA);
        CGRANT   = (state_q == CHROMA);
        XSTROBE  = xstrobe_q;
        XFIRST   = xfirst_q;
        XDATA    = xdata_q;
        XSRC     = xsrc_q;
        INFLIGHT = inflight;
        BUSY     = (state_q != IDLE) || (inflight != '0);
        PROTERR  = proterr_q;
    end

endmodule

// File: tb/tb_h264_xform_arbiter.sv
// Directed self-checking bench for h264_xform_arbiter (BEATS=4, MAX_INFLIGHT=2, DW=36).
module tb_h264_xform_arbiter;

    logic        CLK, RESET;
    logic        LREQ, LSTROBE, LGRANT;
    logic        CREQ, CSTROBE, CGRANT;
    logic [35:0] LDATA, CDATA, XDATA;
    logic        XSTROBE, XSRC, XFIRST, FBSTROBE, BUSY, PROTERR;
    logic [1:0]  INFLIGHT;

    int tests = 0;
    int fails = 0;

    h264_xform_arbiter #(
        .BEATS        (4),
        .MAX_INFLIGHT (2),
        .DW           (36)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .LREQ     (LREQ),
        .LSTROBE  (LSTROBE),
        .LDATA    (LDATA),
        .LGRANT   (LGRANT),
        .CREQ     (CREQ),
        .CSTROBE  (CSTROBE),
        .CDATA    (CDATA),
        .CGRANT   (CGRANT),
        .XSTROBE  (XSTROBE),
        .XDATA    (XDATA),
        .XSRC     (XSRC),
        .XFIRST   (XFIRST),
        .FBSTROBE (FBSTROBE),
        .INFLIGHT (INFLIGHT),
        .BUSY     (BUSY),
        .PROTERR  (PROTERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        LREQ = 0; LSTROBE = 0; LDATA = '0;
        CREQ = 0; CSTROBE = 0; CDATA = '0;
        FBSTROBE = 0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Called in the first granted cycle; returns in the IDLE bubble cycle with strobes low.
    task automatic run_burst(input logic src, input logic [35:0] base);
        for (int i = 0; i < 4; i++) begin
            if (src) begin
                CSTROBE = 1'b1;
                CDATA   = base + 36'(i);
            end else begin
                LSTROBE = 1'b1;
                LDATA   = base + 36'(i);
            end
            tick();
            chk("burst_xstrobe", XSTROBE, 1);
            chk("burst_xdata", XDATA, base + 36'(i));
            chk("burst_xsrc", XSRC, src);
            chk("burst_xfirst", XFIRST, (i == 0));
            chk("burst_grant", src ? CGRANT : LGRANT, (i < 3));
        end
        LSTROBE = 1'b0;
        CSTROBE = 1'b0;
        chk("bubble_lgrant", LGRANT, 0);
        chk("bubble_cgrant", CGRANT, 0);
    endtask

    initial begin
        logic       s;
        logic [6:0] pat;
        int         pulses;

        // Reset state
        do_reset();
        chk("rst_lgrant", LGRANT, 0);
        chk("rst_cgrant", CGRANT, 0);
        chk("rst_xstrobe", XSTROBE, 0);
        chk("rst_xfirst", XFIRST, 0);
        chk("rst_inflight", INFLIGHT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_proterr", PROTERR, 0);

        // Single luma block
        LREQ = 1'b1;
        tick();
        chk("l1_grant", LGRANT, 1);
        chk("l1_inflight", INFLIGHT, 1);
        chk("l1_busy", BUSY, 1);
        LREQ = 1'b0;
        run_burst(1'b0, 36'h1_2345_6780);
        tick();
        chk("l1_xstrobe_off", XSTROBE, 0);
        chk("l1_xdata_hold", XDATA, 36'h1_2345_6783);
        chk("l1_busy_credit", BUSY, 1);
        FBSTROBE = 1'b1;
        tick();
        FBSTROBE = 1'b0;
        chk("l1_fb_inflight", INFLIGHT, 0);
        chk("l1_fb_busy", BUSY, 0);
        chk("l1_proterr", PROTERR, 0);

        // Tie round-robin: L, C, L, C with a credit return in each bubble
        do_reset();
        LREQ = 1'b1;
        CREQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            FBSTROBE = 1'b0;
            s = (k % 2) == 1;
            chk("rr_lgrant", LGRANT, !s);
            chk("rr_cgrant", CGRANT, s);
            chk("rr_inflight", INFLIGHT, 1);
            run_burst(s, 36'h0_0000_0100 * 36'(k + 1));
            FBSTROBE = 1'b1;
            if (k == 3) begin
                LREQ = 1'b0;
                CREQ = 1'b0;
            end
        end
        tick();
        FBSTROBE = 1'b0;
        chk("rr_end_inflight", INFLIGHT, 0);
        chk("rr_end_lgrant", LGRANT, 0);
        chk("rr_end_proterr", PROTERR, 0);

        // Credit throttle at MAX_INFLIGHT = 2
        do_reset();
        LREQ = 1'b1;
        tick();
        chk("cr_grant1", LGRANT, 1);
        run_burst(1'b0, 36'h0_0000_0A00);
        tick();
        chk("cr_grant2", LGRANT, 1);
        chk("cr_inflight2", INFLIGHT, 2);
        run_burst(1'b0, 36'h0_0000_0B00);
        tick();
        chk("cr_stall1", LGRANT, 0);
        chk("cr_stall_inflight", INFLIGHT, 2);
        chk("cr_stall_busy", BUSY, 1);
        tick();
        chk("cr_stall2", LGRANT, 0);
        // Return and request together at INFLIGHT = 2: no grant this cycle
        FBSTROBE = 1'b1;
        tick();
        FBSTROBE = 1'b0;
        chk("cr_fb_nogrant", LGRANT, 0);
        chk("cr_fb_inflight", INFLIGHT, 1);
        tick();
        chk("cr_regrant", LGRANT, 1);
        chk("cr_regrant_inflight", INFLIGHT, 2);
        LREQ = 1'b0;
        run_burst(1'b0, 36'h0_0000_0C00);
        chk("cr_proterr", PROTERR, 0);

        // Strobe gaps and a stray chroma strobe
        do_reset();
        LREQ = 1'b1;
        tick();
        chk("gap_grant", LGRANT, 1);
        LREQ   = 1'b0;
        pat    = 7'b1100101;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            LSTROBE = pat[i];
            LDATA   = 36'h0_0000_0100 + 36'(i);
            CSTROBE = (i == 1);
            CDATA   = 36'hF_FFFF_FFFF;
            tick();
            if (XSTROBE) pulses++;
            if (i == 0) begin
                chk("gap_first", XFIRST, 1);
                chk("gap_proterr_pre", PROTERR, 0);
            end
        end
        LSTROBE = 1'b0;
        CSTROBE = 1'b0;
        chk("gap_pulses", pulses, 4);
        chk("gap_end_grant", LGRANT, 0);
        chk("gap_last_data", XDATA, 36'h0_0000_0106);
        chk("gap_xsrc", XSRC, 0);
        chk("gap_proterr", PROTERR, 1);

        // Reset mid-burst, then a fresh burst
        do_reset();
        LREQ = 1'b1;
        tick();
        LREQ    = 1'b0;
        LSTROBE = 1'b1;
        LDATA   = 36'h0_0000_0D00;
        tick();
        LDATA = 36'h0_0000_0D01;
        tick();
        chk("mr_pre_xstrobe", XSTROBE, 1);
        RESET = 1'b1;
        #1;
        chk("mr_lgrant", LGRANT, 0);
        chk("mr_xstrobe", XSTROBE, 0);
        chk("mr_inflight", INFLIGHT, 0);
        chk("mr_busy", BUSY, 0);
        LSTROBE = 1'b0;
        tick();
        RESET = 1'b0;
        LREQ  = 1'b1;
        tick();
        chk("mr_regrant", LGRANT, 1);
        chk("mr_inflight1", INFLIGHT, 1);
        LREQ = 1'b0;
        run_burst(1'b0, 36'h0_0000_0E00);

        // Credit return underflow
        FBSTROBE = 1'b1;
        tick();
        FBSTROBE = 1'b0;
        chk("uf_inflight0", INFLIGHT, 0);
        chk("uf_proterr_pre", PROTERR, 0);
        FBSTROBE = 1'b1;
        tick();
        FBSTROBE = 1'b0;
        chk("uf_inflight", INFLIGHT, 0);
        chk("uf_proterr", PROTERR, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
